// File: rtl/shared_mem_arbiter.sv
// rtl/shared_mem_arbiter.sv - round-robin arbiter sharing one single-port memory
// between the instruction-fetch port and the load/store port.
module shared_mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] LAT = 4'(READ_LAT);

  state_t            state_q, state_d;
  logic              last_dm_q, last_dm_d;
  logic              gnt_dm_q, gnt_dm_d;
  logic              we_q, we_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              pick_dm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      last_dm_q   <= 1'b0;
      gnt_dm_q    <= 1'b0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_dm_q   <= last_dm_d;
      gnt_dm_q    <= gnt_dm_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_dm_d   = last_dm_q;
    gnt_dm_d    = gnt_dm_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    pick_dm     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (if_req || dm_req) begin
          // On a tie the port that did not win last time is served.
          pick_dm     = dm_req && (!if_req || !last_dm_q);
          gnt_dm_d    = pick_dm;
          last_dm_d   = pick_dm;
          we_d        = pick_dm && dm_we;
          mem_addr_d  = pick_dm ? dm_addr : if_addr;
          mem_wdata_d = pick_dm ? dm_wdata : '0;
          state_d     = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (we_q) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = LAT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          if (gnt_dm_q) dm_rdata_d = mem_rdata;
          else          if_rdata_d = mem_rdata;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_en    = (state_q == S_ACCESS);
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_done   = (state_q == S_DONE) && !gnt_dm_q;
  assign dm_done   = (state_q == S_DONE) && gnt_dm_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// tb/tb_shared_mem_arbiter.sv - directed bench for shared_mem_arbiter
module tb_shared_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // instance A: READ_LAT=1
  logic        if_req_a = 0, dm_req_a = 0, dm_we_a = 0;
  logic [31:0] if_addr_a = 0, dm_addr_a = 0, dm_wdata_a = 0;
  logic [31:0] if_rdata_a, dm_rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
  logic        if_done_a, dm_done_a, mem_en_a, mem_we_a, busy_a;

  // instance B: READ_LAT=3
  logic        if_req_b = 0, dm_req_b = 0, dm_we_b = 0;
  logic [31:0] if_addr_b = 0, dm_addr_b = 0, dm_wdata_b = 0;
  logic [31:0] if_rdata_b, dm_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
  logic        if_done_b, dm_done_b, mem_en_b, mem_we_b, busy_b;

  shared_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(1)) u_a (
    .clk(clk), .rst(rst),
    .if_req(if_req_a), .if_addr(if_addr_a), .if_rdata(if_rdata_a), .if_done(if_done_a),
    .dm_req(dm_req_a), .dm_we(dm_we_a), .dm_addr(dm_addr_a), .dm_wdata(dm_wdata_a),
    .dm_rdata(dm_rdata_a), .dm_done(dm_done_a),
    .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .mem_rdata(mem_rdata_a), .busy(busy_a)
  );

  shared_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(3)) u_b (
    .clk(clk), .rst(rst),
    .if_req(if_req_b), .if_addr(if_addr_b), .if_rdata(if_rdata_b), .if_done(if_done_b),
    .dm_req(dm_req_b), .dm_we(dm_we_b), .dm_addr(dm_addr_b), .dm_wdata(dm_wdata_b),
    .dm_rdata(dm_rdata_b), .dm_done(dm_done_b),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata_b), .busy(busy_b)
  );

  function automatic logic [31:0] init_word(input logic [31:0] addr);
    case (addr)
      32'h4:   return 32'h2008_0005;
      32'h40:  return 32'h1234_5678;
      default: return addr ^ 32'hA5A5_0000;
    endcase
  endfunction

  // Memory models: read data is only valid in the exact cycle READ_LAT after mem_en.
  bit [31:0]   mem_a [0:255];
  bit          wr_a  [0:255];
  int          rd_cnt_a = 0;
  logic [31:0] rd_word_a = 0;
  always @(posedge clk) begin
    if (rd_cnt_a > 0) rd_cnt_a <= rd_cnt_a - 1;
    if (mem_en_a && mem_we_a) begin
      mem_a[mem_addr_a[9:2]] <= mem_wdata_a;
      wr_a[mem_addr_a[9:2]]  <= 1'b1;
    end
    if (mem_en_a && !mem_we_a) begin
      rd_cnt_a  <= 1;
      rd_word_a <= wr_a[mem_addr_a[9:2]] ? mem_a[mem_addr_a[9:2]] : init_word(mem_addr_a);
    end
  end
  assign mem_rdata_a = (rd_cnt_a == 1) ? rd_word_a : 32'hBAD0_BAD0;

  int          rd_cnt_b = 0;
  logic [31:0] rd_word_b = 0;
  always @(posedge clk) begin
    if (rd_cnt_b > 0) rd_cnt_b <= rd_cnt_b - 1;
    if (mem_en_b && !mem_we_b) begin
      rd_cnt_b  <= 3;
      rd_word_b <= init_word(mem_addr_b);
    end
  end
  assign mem_rdata_b = (rd_cnt_b == 1) ? rd_word_b : 32'hBAD0_BAD0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          dm;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  logic [31:0] exp_if_rd = 0;
  logic [31:0] exp_dm_rd = 0;

  task automatic do_access(input vec_t v, input int idx);
    int          cyc = 0, en_cnt = 0, en_cyc = 0;
    bit          done_seen = 0, we_seen = 0;
    logic [31:0] addr_seen = 0, wdata_seen = 0;
    if (v.dm) begin
      dm_req_a = 1; dm_we_a = v.we; dm_addr_a = v.addr; dm_wdata_a = v.wdata;
    end else begin
      if_req_a = 1; if_addr_a = v.addr;
    end
    while (!done_seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (mem_en_a) begin
        en_cnt++; en_cyc = cyc; we_seen = mem_we_a;
        addr_seen = mem_addr_a; wdata_seen = mem_wdata_a;
      end
      if (v.dm ? dm_done_a : if_done_a) done_seen = 1;
    end
    if (!v.we) begin
      if (v.dm) exp_dm_rd = v.rdata;
      else      exp_if_rd = v.rdata;
    end
    chk($sformatf("v%0d done_seen", idx), 32'(done_seen), 32'd1);
    chk($sformatf("v%0d latency", idx), cyc, v.lat);
    chk($sformatf("v%0d mem_en_count", idx), en_cnt, 1);
    chk($sformatf("v%0d mem_en_cycle", idx), en_cyc, 1);
    chk($sformatf("v%0d mem_we", idx), 32'(we_seen), 32'(v.we));
    chk($sformatf("v%0d mem_addr", idx), addr_seen, v.addr);
    if (v.we) chk($sformatf("v%0d mem_wdata", idx), wdata_seen, v.wdata);
    chk($sformatf("v%0d if_rdata", idx), if_rdata_a, exp_if_rd);
    chk($sformatf("v%0d dm_rdata", idx), dm_rdata_a, exp_dm_rd);
    chk($sformatf("v%0d other_done", idx), 32'(v.dm ? if_done_a : dm_done_a), 32'd0);
    if_req_a = 0; dm_req_a = 0; dm_we_a = 0;
    @(negedge clk);
    chk($sformatf("v%0d done_pulse_width", idx), 32'(if_done_a | dm_done_a), 32'd0);
    chk($sformatf("v%0d busy_after", idx), 32'(busy_a), 32'd0);
  endtask

  // who: 1 = fetch port completed, 2 = data port completed, 0 = timeout
  task automatic wait_done_a(output int who);
    int cyc = 0;
    who = 0;
    while (who == 0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (if_done_a && dm_done_a) who = 3;
      else if (dm_done_a)         who = 2;
      else if (if_done_a)         who = 1;
    end
  endtask

  vec_t vecs[8];

  initial begin
    int who;
    int done_cyc, en_mask, busy_mask, done_cnt;

    vecs[0] = '{dm: 0, we: 0, addr: 32'h04, wdata: 32'h0,         rdata: 32'h2008_0005, lat: 3};
    vecs[1] = '{dm: 1, we: 1, addr: 32'h10, wdata: 32'hDEAD_BEEF, rdata: 32'h0,         lat: 2};
    vecs[2] = '{dm: 1, we: 0, addr: 32'h10, wdata: 32'h0,         rdata: 32'hDEAD_BEEF, lat: 3};
    vecs[3] = '{dm: 0, we: 0, addr: 32'h10, wdata: 32'h0,         rdata: 32'hDEAD_BEEF, lat: 3};
    vecs[4] = '{dm: 1, we: 0, addr: 32'h08, wdata: 32'h0,         rdata: 32'hA5A5_0008, lat: 3};
    vecs[5] = '{dm: 1, we: 1, addr: 32'h08, wdata: 32'h0000_0001, rdata: 32'h0,         lat: 2};
    vecs[6] = '{dm: 0, we: 0, addr: 32'h08, wdata: 32'h0,         rdata: 32'h0000_0001, lat: 3};
    vecs[7] = '{dm: 1, we: 0, addr: 32'hFC, wdata: 32'h0,         rdata: 32'hA5A5_00FC, lat: 3};

    #1;
    chk("reset mem_en", 32'(mem_en_a), 0);
    chk("reset mem_we", 32'(mem_we_a), 0);
    chk("reset mem_addr", mem_addr_a, 0);
    chk("reset mem_wdata", mem_wdata_a, 0);
    chk("reset rdata", if_rdata_a | dm_rdata_a, 0);
    chk("reset done_busy", 32'({if_done_a, dm_done_a, busy_a}), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) do_access(vecs[i], i);

    // Tie right after reset: data first, then the still-waiting fetch.
    rst = 1;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    dm_req_a = 1; dm_we_a = 0; dm_addr_a = 32'h20;
    if_req_a = 1; if_addr_a = 32'h24;
    wait_done_a(who);
    chk("tie first grant", who, 2);
    chk("tie dm_rdata", dm_rdata_a, 32'hA5A5_0020);
    dm_req_a = 0;
    wait_done_a(who);
    chk("tie second grant", who, 1);
    chk("tie if_rdata", if_rdata_a, 32'hA5A5_0024);
    chk("tie dm_rdata kept", dm_rdata_a, 32'hA5A5_0020);
    if_req_a = 0;
    @(negedge clk);

    // Both held continuously: strict alternation starting with data.
    dm_req_a = 1; if_req_a = 1;
    for (int k = 0; k < 6; k++) begin
      wait_done_a(who);
      chk($sformatf("rr grant %0d", k), who, (k % 2 == 0) ? 2 : 1);
    end
    dm_req_a = 0; if_req_a = 0;
    @(negedge clk);
    @(negedge clk);

    // READ_LAT=3 load timing.
    dm_req_b = 1; dm_we_b = 0; dm_addr_b = 32'h40;
    done_cyc = 0; en_mask = 0; busy_mask = 0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (mem_en_b) en_mask |= (1 << c);
      if (busy_b)   busy_mask |= (1 << c);
      if (dm_done_b) begin
        done_cyc = c;
        dm_req_b = 0;
      end
    end
    chk("lat3 done cycle", done_cyc, 5);
    chk("lat3 mem_en cycles", en_mask, 32'h02);
    chk("lat3 busy cycles", busy_mask, 32'h3E);
    chk("lat3 dm_rdata", dm_rdata_b, 32'h1234_5678);

    // Reset while in WAIT.
    dm_req_b = 1; dm_we_b = 0; dm_addr_b = 32'h44;
    @(negedge clk);
    @(negedge clk);
    chk("wait busy before rst", 32'(busy_b), 1);
    rst = 1;
    dm_req_b = 0;
    #1;
    chk("rst mid mem_en_we", 32'({mem_en_b, mem_we_b}), 0);
    chk("rst mid mem_addr", mem_addr_b, 0);
    chk("rst mid rdata", if_rdata_b | dm_rdata_b, 0);
    chk("rst mid done_busy", 32'({if_done_b, dm_done_b, busy_b}), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    done_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (if_done_b || dm_done_b) done_cnt++;
    end
    chk("rst no done pulse", done_cnt, 0);
    if_req_b = 1; if_addr_b = 32'h4;
    done_cyc = 0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (if_done_b) begin
        done_cyc = c;
        if_req_b = 0;
      end
    end
    chk("post rst fetch done cycle", done_cyc, 5);
    chk("post rst if_rdata", if_rdata_b, 32'h2008_0005);
    chk("post rst busy", 32'(busy_b), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
